// File: rtl/streaming_pipeline_pkg.sv
// Shared constants and the feeder state type for the streaming count-connected pipeline.
package streaming_pipeline_pkg;

    localparam int unsigned GRAPH_WIDTH         = 128;
    localparam int unsigned CONNECT_COUNT_WIDTH = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN_ISSUE,
        S_DRAIN_WAIT,
        S_DONE
    } feederState_e;

endpackage

// File: rtl/feeder_skid_fifo.sv
// Show-ahead skid FIFO with registered full/empty flags; pointers carry one extra wrap bit.
module feeder_skid_fifo #(
    parameter int unsigned WIDTH      = 130,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtrNext;
    logic [PTR_W-1:0] rdPtrNext;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr[DEPTH_LOG2-1:0]];

    always_comb begin
        wrPtrNext = wrPtr + PTR_W'(doPush);
        rdPtrNext = rdPtr + PTR_W'(doPop);
    end

    // Flags are computed from next pointers so they are valid straight out of the flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            empty <= (wrPtrNext == rdPtrNext);
            full  <= (wrPtrNext[DEPTH_LOG2] != rdPtrNext[DEPTH_LOG2]) &&
                     (wrPtrNext[DEPTH_LOG2-1:0] == rdPtrNext[DEPTH_LOG2-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[DEPTH_LOG2-1:0]] <= din;
        end
    end

endmodule

// File: rtl/streaming_graph_feeder.sv
// Issue-side feeder for the count-connected core: skid-buffers graphs, issues under backpressure,
// tracks bots in flight and flags job drain. FEEDER_STALL_COUNTER_EN adds the stallCycles counter.
module streaming_graph_feeder
    import streaming_pipeline_pkg::*;
#(
    parameter int unsigned EXTRA_DATA_WIDTH  = 1,
    parameter int unsigned OUTSTANDING_WIDTH = 16,
    parameter int unsigned SKID_DEPTH_LOG2   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         srcValid,
    input  logic [GRAPH_WIDTH-1:0]       srcGraph,
    input  logic [EXTRA_DATA_WIDTH-1:0]  srcExtra,
    input  logic                         srcLast,
    output logic                         srcReady,
    output logic                         isBotValid,
    output logic [GRAPH_WIDTH-1:0]       graphOut,
    output logic [EXTRA_DATA_WIDTH-1:0]  extraDataOut,
    input  logic                         slowDownInput,
    input  logic                         resultValid,
    output logic [OUTSTANDING_WIDTH-1:0] outstanding,
    output logic                         busy,
    output logic                         jobDone,
`ifdef FEEDER_STALL_COUNTER_EN
    output logic [31:0]                  stallCycles,
`endif
    output logic                         protocolError
);

    localparam int unsigned FIFO_WIDTH = GRAPH_WIDTH + EXTRA_DATA_WIDTH + 1;

    feederState_e                 state;
    feederState_e                 stateNext;
    logic                         resetDone;
    logic                         slowRegistered;
    logic                         strayWindow;
    logic                         fifoFull;
    logic                         fifoEmpty;
    logic [FIFO_WIDTH-1:0]        fifoHead;
    logic [GRAPH_WIDTH-1:0]       headGraph;
    logic [EXTRA_DATA_WIDTH-1:0]  headExtra;
    logic                         unusedHeadLast;
    logic                         accept;
    logic                         issue;
    logic                         underflow;
    logic [OUTSTANDING_WIDTH-1:0] outstandingNext;

    assign {unusedHeadLast, headExtra, headGraph} = fifoHead;
    assign accept = srcValid && srcReady;
    assign issue  = !fifoEmpty && !slowRegistered && (outstanding != '1) &&
                    ((state == S_STREAM) || (state == S_DRAIN_ISSUE));

    feeder_skid_fifo #(
        .WIDTH      (FIFO_WIDTH),
        .DEPTH_LOG2 (SKID_DEPTH_LOG2)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({srcLast, srcExtra, srcGraph}),
        .pop   (issue),
        .dout  (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // In-flight accounting; results arriving before the first accept after reset are stale.
    always_comb begin
        outstandingNext = outstanding;
        underflow       = 1'b0;
        if (issue && !resultValid) begin
            outstandingNext = outstanding + OUTSTANDING_WIDTH'(1);
        end else if (!issue && resultValid) begin
            if (outstanding == '0) begin
                underflow = !strayWindow;
            end else begin
                outstandingNext = outstanding - OUTSTANDING_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE:        if (accept) stateNext = srcLast ? S_DRAIN_ISSUE : S_STREAM;
            S_STREAM:      if (accept && srcLast) stateNext = S_DRAIN_ISSUE;
            S_DRAIN_ISSUE: if (fifoEmpty) stateNext = S_DRAIN_WAIT;
            S_DRAIN_WAIT:  if (outstandingNext == '0) stateNext = S_DONE;
            S_DONE:        stateNext = S_IDLE;
            default:       stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        srcReady = 1'b0;
        busy     = 1'b0;
        jobDone  = 1'b0;
        srcReady = resetDone && !fifoFull && ((state == S_IDLE) || (state == S_STREAM));
        busy     = (state != S_IDLE);
        jobDone  = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resetDone      <= 1'b0;
            slowRegistered <= 1'b0;
            strayWindow    <= 1'b1;
            outstanding    <= '0;
            protocolError  <= 1'b0;
            isBotValid     <= 1'b0;
            graphOut       <= '0;
            extraDataOut   <= '0;
        end else begin
            resetDone      <= 1'b1;
            slowRegistered <= slowDownInput;
            outstanding    <= outstandingNext;
            isBotValid     <= issue;
            if (accept) begin
                strayWindow <= 1'b0;
            end
            if (underflow) begin
                protocolError <= 1'b1;
            end
            if (issue) begin
                graphOut     <= headGraph;
                extraDataOut <= headExtra;
            end
        end
    end

`ifdef FEEDER_STALL_COUNTER_EN
    // Cycles with work queued but held off by the core's slowdown request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCycles <= '0;
        end else if ((state == S_IDLE) && (stateNext != S_IDLE)) begin
            stallCycles <= '0;
        end else if (!fifoEmpty && slowRegistered && (stallCycles != '1)) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_streaming_graph_feeder.sv
// Randomized self-checking bench for streaming_graph_feeder against a queue-based job model.
module tb_streaming_graph_feeder;

    localparam int EW = 1;
    localparam int OW = 16;
    localparam int P_IDLE = 0;
    localparam int P_STREAM = 1;
    localparam int P_DRAIN_ISSUE = 2;
    localparam int P_DRAIN_WAIT = 3;
    localparam int P_DONE = 4;

    typedef struct packed {
        logic [127:0]  g;
        logic [EW-1:0] e;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          srcValid;
    logic [127:0]  srcGraph;
    logic [EW-1:0] srcExtra;
    logic          srcLast;
    logic          srcReady;
    logic          isBotValid;
    logic [127:0]  graphOut;
    logic [EW-1:0] extraDataOut;
    logic          slowDownInput;
    logic          resultValid;
    logic [OW-1:0] outstanding;
    logic          busy;
    logic          jobDone;
    logic          protocolError;
`ifdef FEEDER_STALL_COUNTER_EN
    logic [31:0]   stallCycles;
`endif

    always #5 clk = ~clk;

    streaming_graph_feeder #(
        .EXTRA_DATA_WIDTH  (EW),
        .OUTSTANDING_WIDTH (OW),
        .SKID_DEPTH_LOG2   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .srcValid      (srcValid),
        .srcGraph      (srcGraph),
        .srcExtra      (srcExtra),
        .srcLast       (srcLast),
        .srcReady      (srcReady),
        .isBotValid    (isBotValid),
        .graphOut      (graphOut),
        .extraDataOut  (extraDataOut),
        .slowDownInput (slowDownInput),
        .resultValid   (resultValid),
        .outstanding   (outstanding),
        .busy          (busy),
        .jobDone       (jobDone),
`ifdef FEEDER_STALL_COUNTER_EN
        .stallCycles   (stallCycles),
`endif
        .protocolError (protocolError)
    );

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;

    // Model: FIFO contents, in-flight count, job phase and registered output images.
    beat_t srcQ[$];
    beat_t mq[$];
    beat_t sentLog[$];
    beat_t dutIssued[$];
    int    dueQ[$];
    int    mOut;
    int    phase;
    bit    mErr, mStray, mRdone, mSlow, mValid;
    logic [127:0]  mGraph;
    logic [EW-1:0] mExtra;

    int gapPct = 0, slowPct = 0, latMin = 22, latMax = 22, slowFrom = -1000, slowLen = 0;
    bit slowLevel = 0, serveResults = 1, forceRes = 0;

    int nIssue, firstIssueCyc, lastIssueCyc, peakOut, nDone, doneCyc, lastResCyc;
    int winLo, winHi, winIssues;
    bit sawNotReady;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic modelReset();
        mq.delete(); srcQ.delete(); dueQ.delete();
        mOut = 0; phase = P_IDLE;
        mErr = 0; mStray = 1; mRdone = 0; mSlow = 0; mValid = 0;
        mGraph = '0; mExtra = '0;
    endtask

    task automatic clearStats();
        nIssue = 0; firstIssueCyc = -1; lastIssueCyc = -1; peakOut = 0;
        nDone = 0; doneCyc = -1; lastResCyc = -1;
        winLo = 1; winHi = 0; winIssues = 0; sawNotReady = 0;
        sentLog.delete(); dutIssued.delete();
    endtask

    task automatic queueJob(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.g = {$urandom, $urandom, $urandom, $urandom};
            b.e = EW'($urandom);
            b.l = (i == n - 1);
            srcQ.push_back(b);
        end
    endtask

    task automatic compareAll();
        bit expReady;
        expReady = mRdone && (mq.size() < 4) && (phase <= P_STREAM);
        chk("srcReady", 128'(srcReady), 128'(expReady));
        chk("isBotValid", 128'(isBotValid), 128'(mValid));
        chk("graphOut", graphOut, mGraph);
        chk("extraDataOut", 128'(extraDataOut), 128'(mExtra));
        chk("outstanding", 128'(outstanding), 128'(mOut));
        chk("busy", 128'(busy), 128'(phase != P_IDLE));
        chk("jobDone", 128'(jobDone), 128'(phase == P_DONE));
        chk("protocolError", 128'(protocolError), 128'(mErr));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic step();
        bit ready, acc, iss, res, fromQ;
        beat_t b;
        ready = mRdone && (mq.size() < 4) && (phase <= P_STREAM);
        srcValid = (srcQ.size() > 0) && (int'($urandom_range(0, 99)) >= gapPct);
        if (srcQ.size() > 0) begin
            srcGraph = srcQ[0].g; srcExtra = srcQ[0].e; srcLast = srcQ[0].l;
        end else begin
            srcGraph = {$urandom, $urandom, $urandom, $urandom}; srcExtra = EW'($urandom); srcLast = 1'b0;
        end
        fromQ = serveResults && (dueQ.size() > 0) && (dueQ[0] <= cyc);
        res = forceRes || fromQ;
        resultValid = res;
        slowDownInput = slowLevel || ((cyc >= slowFrom) && (cyc < slowFrom + slowLen)) ||
                        (int'($urandom_range(0, 99)) < slowPct);
        if (res) lastResCyc = cyc;
        @(posedge clk);
        acc = srcValid && ready;
        iss = (mq.size() > 0) && !mSlow && (mOut != 65535) &&
              ((phase == P_STREAM) || (phase == P_DRAIN_ISSUE));
        if (fromQ) void'(dueQ.pop_front());
        if (iss && !res) mOut++;
        else if (!iss && res) begin
            if (mOut == 0) begin
                if (!mStray) mErr = 1;
            end else mOut--;
        end
        case (phase)
            P_IDLE:        if (acc) phase = srcLast ? P_DRAIN_ISSUE : P_STREAM;
            P_STREAM:      if (acc && srcLast) phase = P_DRAIN_ISSUE;
            P_DRAIN_ISSUE: if (mq.size() == 0) phase = P_DRAIN_WAIT;
            P_DRAIN_WAIT:  if (mOut == 0) phase = P_DONE;
            default:       phase = P_IDLE;
        endcase
        if (iss) begin
            b = mq.pop_front();
            mValid = 1; mGraph = b.g; mExtra = b.e;
            dueQ.push_back(cyc + 1 + int'($urandom_range(latMin, latMax)));
        end else mValid = 0;
        if (acc) begin
            b = srcQ.pop_front();
            mq.push_back(b); sentLog.push_back(b);
            mStray = 0;
        end
        mSlow = slowDownInput;
        mRdone = 1;
        cyc++;
        @(negedge clk);
        compareAll();
        if (isBotValid === 1'b1) begin
            nIssue++;
            if (firstIssueCyc < 0) firstIssueCyc = cyc;
            lastIssueCyc = cyc;
            if (cyc >= winLo && cyc <= winHi) winIssues++;
            dutIssued.push_back({graphOut, extraDataOut, 1'b0});
        end
        if (int'(outstanding) > peakOut) peakOut = int'(outstanding);
        if (jobDone === 1'b1) begin nDone++; doneCyc = cyc; end
        if (srcReady === 1'b0 && cyc >= winLo && cyc <= winHi) sawNotReady = 1;
    endtask

    task automatic runJob(input int budget);
        int n;
        bit fin;
        n = 0; fin = 0;
        while (!fin && n < budget) begin
            step();
            n++;
            fin = (phase == P_IDLE) && (srcQ.size() == 0) && (mq.size() == 0) && (dueQ.size() == 0);
        end
        if (!fin) begin
            nChecks++;
            $display("FAIL jobTimeout (cycle %0d): got no drain within %0d cycles, required drain", cyc, budget);
        end
    endtask

    task automatic chkOrder(input int expN);
        chk("issuedCount", 128'(dutIssued.size()), 128'(expN));
        for (int i = 0; i < sentLog.size() && i < dutIssued.size(); i++) begin
            chk("orderGraph", dutIssued[i].g, sentLog[i].g);
            chk("orderExtra", 128'(dutIssued[i].e), 128'(sentLog[i].e));
        end
    endtask

    initial begin
        rst = 1'b0; srcValid = 0; srcGraph = '0; srcExtra = '0; srcLast = 0;
        slowDownInput = 0; resultValid = 0;
        modelReset();
        clearStats();
        repeat (2) @(negedge clk);
        chk("rstReady", 128'(srcReady), 128'(0));
        chk("rstValid", 128'(isBotValid), 128'(0));
        chk("rstOutstanding", 128'(outstanding), 128'(0));
        chk("rstBusy", 128'(busy), 128'(0));
        chk("rstErr", 128'(protocolError), 128'(0));
        rst = 1'b1;
        step();
        chk("readyAfterRelease", 128'(srcReady), 128'(1));

        // Three-graph job, fixed 22-cycle result latency.
        queueJob(3); clearStats();
        runJob(300);
        chk("t1Issues", 128'(nIssue), 128'(3));
        chk("t1Consecutive", 128'(lastIssueCyc - firstIssueCyc), 128'(2));
        chk("t1Peak", 128'(peakOut), 128'(3));
        chk("t1DoneCount", 128'(nDone), 128'(1));
        chk("t1DoneLag", 128'(doneCyc - lastResCyc), 128'(1));
        chk("t1Idle", 128'(busy), 128'(0));

        // Twenty-graph stream with a 10-cycle slowdown.
        latMin = 3; latMax = 40;
        queueJob(20); clearStats();
        slowFrom = cyc + 8; slowLen = 10;
        winLo = slowFrom + 1; winHi = slowFrom + 11;
        runJob(600);
        chk("t2IssuesAfterSlow", 128'(winIssues <= 1), 128'(1));
        chk("t2FifoFilled", 128'(sawNotReady), 128'(1));
        chkOrder(20);
`ifdef FEEDER_STALL_COUNTER_EN
        chk("t2StallCycles", 128'(stallCycles), 128'(10));
`endif
        slowFrom = -1000; slowLen = 0;

        // Latency 4 keeps the counter pinned at 5 while issues and results coincide.
        latMin = 4; latMax = 4;
        queueJob(10); clearStats();
        runJob(300);
        chk("t3Peak", 128'(peakOut), 128'(5));
        chk("t3Issues", 128'(nIssue), 128'(10));

        // Single-graph job.
        latMin = 2; latMax = 6;
        queueJob(1); clearStats();
        runJob(100);
        chk("singleIssues", 128'(nIssue), 128'(1));
        chk("singleDone", 128'(nDone), 128'(1));

        // Underflow while idle.
        forceRes = 1; step(); forceRes = 0;
        repeat (3) step();
        chk("underflowErr", 128'(protocolError), 128'(1));
        chk("underflowCount", 128'(outstanding), 128'(0));

        // Reset with 7 in flight and 2 queued, then stale results.
        serveResults = 0; latMin = 2; latMax = 6;
        queueJob(9); clearStats();
        for (int i = 0; i < 60 && mOut < 6; i++) step();
        slowLevel = 1;
        repeat (4) step();
        chk("preRstOutstanding", 128'(outstanding), 128'(7));
        rst = 1'b0;
        #1;
        chk("asyncRstReady", 128'(srcReady), 128'(0));
        chk("asyncRstValid", 128'(isBotValid), 128'(0));
        chk("asyncRstGraph", graphOut, 128'(0));
        chk("asyncRstOutstanding", 128'(outstanding), 128'(0));
        chk("asyncRstBusy", 128'(busy), 128'(0));
        chk("asyncRstErr", 128'(protocolError), 128'(0));
        modelReset();
        slowLevel = 0; srcValid = 0; resultValid = 0; slowDownInput = 0;
        @(negedge clk);
        rst = 1'b1;
        serveResults = 1; clearStats();
        for (int i = 0; i < 7; i++) begin
            forceRes = 1; step(); forceRes = 0; step();
        end
        chk("strayNoErr", 128'(protocolError), 128'(0));
        chk("strayNoDone", 128'(nDone), 128'(0));

        // Random jobs with gaps, random slowdown and random latency.
        gapPct = 30; slowPct = 20; latMin = 1; latMax = 30;
        for (int j = 0; j < 3; j++) begin
            int n;
            n = 1 + int'($urandom_range(0, 23));
            queueJob(n); clearStats();
            runJob(3000);
            chkOrder(n);
            chk("randDone", 128'(nDone), 128'(1));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
